encode_hex_tx: RTL
==================

ENCODE_HEX_TX -- requirements
Module: encode_hex_tx

Interface
REQ-001 SHALL provide parameter NDIG, default 4, number of hex digits sent per message (1-8).
REQ-002 SHALL provide parameter UPPER, default 0, where 0 selects letters a-f (0x61-0x66) and 1 selects A-F (0x41-0x46).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port value  input  NDIG*4  magnitude to print, MSB nibble first.
REQ-006 SHALL have port neg  input  1  sign prefix select: 1 gives '-' (0x2D), 0 gives '+' (0x2B).
REQ-007 SHALL have port send  input  1  start request, sampled only in IDLE.
REQ-008 SHALL have port abort  input  1  terminate the message in progress with ESC (0x1B).
REQ-009 SHALL have port txReady  input  1  UART transmitter can accept txData this cycle.
REQ-010 SHALL have port txData  output  8  ASCII character to transmit.
REQ-011 SHALL have port txValid  output  1  txData is valid.
REQ-012 SHALL have port busy  output  1  high from the cycle after send is accepted until done.
REQ-013 SHALL have port done  output  1  one-cycle pulse at message end.

Function
REQ-014 SHALL send this message: sign char, NDIG hex digits MSB first, CR (0x0D), LF (0x0A), for NDIG+3 chars total.
REQ-015 SHALL map nibbles 0-9 to 0x30-0x39 and nibbles 10-15 per UPPER.
REQ-016 SHALL register the output side: txData, txValid, busy and done are flops, with no combinational path from inputs to outputs.
REQ-017 SHALL use FSM states IDLE, SIGN, DIGIT, CR, LF, ESC, plus a digit counter running 0..NDIG-1.
REQ-018 SHALL, in IDLE with send=1, capture value and neg, go to SIGN, and assert txValid and busy on the next cycle (latency 1).
REQ-019 SHALL ignore send while busy; the captured value and neg are unaffected by input changes during a message.
REQ-020 SHALL treat a transfer as a cycle with txValid=1 and txReady=1.
REQ-021 SHALL hold txData stable and keep txValid high until that transfer occurs.
REQ-022 SHALL present the next char in the cycle after a transfer, so txValid stays high and chars go back-to-back when txReady stays high.
REQ-023 SHALL make these transitions on transfer: SIGN->DIGIT (counter=0); DIGIT->DIGIT (counter+1) while counter<NDIG-1; last DIGIT->CR; CR->LF; LF->IDLE.
REQ-024 SHALL, on leaving LF or ESC, drop txValid and busy and pulse done for one cycle in the next cycle.
REQ-025 SHALL accept a new send in the same cycle that done is high, because the FSM is already in IDLE.
REQ-026 SHALL, when abort=1 while busy and not in ESC, latch abort_pend.
REQ-027 SHALL, once abort_pend is set, complete the char currently offered and then go to ESC instead of the normal next state.
REQ-028 SHALL, when abort and a transfer occur in the same cycle, go directly to ESC.
REQ-029 SHALL, in ESC, offer 0x1B until transferred, then finish per REQ-024, then clear abort_pend.
REQ-030 SHALL ignore abort in IDLE, including in the cycle where send is accepted, and in ESC.
REQ-031 SHALL never send CR or LF after an ESC.

Reset
REQ-032 SHALL, with rst_n low, immediately force state=IDLE, txValid=0, busy=0, done=0, txData=0x00, counter=0, abort_pend=0.
REQ-033 SHALL, on reset mid-message, drop the partial message without sending ESC; the first send after rst_n rises starts a fresh message.

Verification
REQ-034 SHALL be checked with NDIG=4, UPPER=0, txReady=1, value=0x1A2F, neg=0, send pulse at cycle 0 -> txData 2B,31,61,32,66,0D,0A on cycles 1-7, and done=1 at cycle 8 only.
REQ-035 SHALL be checked with value=0x00F0, neg=1, UPPER=1, txReady toggling 1,0,1,0 -> sequence 2D,30,30,46,30,0D,0A, with txData stable during every txReady=0 cycle and no char lost or duplicated.
REQ-036 SHALL be checked with value=0x1234, txReady=1, abort pulsed while '2' (0x32) is offered -> 2B,31,32,1B, then done, with no 0x0D or 0x0A.
REQ-037 SHALL be checked with txReady=0 and abort pulsed during SIGN -> 0x2B is held; when txReady rises, 0x2B then 0x1B are sent, then done.
REQ-038 SHALL be checked by asserting rst_n=0 during the DIGIT state -> txValid=0 and busy=0 without waiting for a clock edge; a subsequent send of 0xFFFF gives 2B,66,66,66,66,0D,0A.
REQ-039 SHALL be checked with send held high continuously -> back-to-back messages, each new one starting the cycle after done, and send ignored mid-message.

Source files
------------

// File: rtl/encode_hex_tx.sv
// rtl/encode_hex_tx.sv - signed hex value to ASCII line transmitter for a UART
//
// Sends one message per accepted request: sign char, NDIG hex digits (MSB
// first), CR, LF. An abort ends the message early with a single ESC char.
//
// Ports:
//   clk      - clock, all state on rising edge
//   rst_n    - asynchronous active-low reset
//   value    - NDIG*4-bit magnitude to print, MSB nibble first
//   neg      - sign select: 1 = '-', 0 = '+'
//   send     - start request, sampled only in IDLE
//   abort    - end the message in progress with ESC
//   txReady  - UART can accept txData this cycle
//   txData   - ASCII char offered to the UART (registered)
//   txValid  - txData is valid (registered)
//   busy     - message in progress (registered)
//   done     - one-cycle pulse after the last char of a message (registered)

module encode_hex_tx #(
    parameter int NDIG  = 4,
    parameter int UPPER = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NDIG*4-1:0] value,
    input  logic              neg,
    input  logic              send,
    input  logic              abort,
    input  logic              txReady,
    output logic [7:0]        txData,
    output logic              txValid,
    output logic              busy,
    output logic              done
);

    localparam int W  = NDIG * 4;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_ESC   = 8'h1B;

    typedef enum logic [2:0] {
        IDLE,
        SIGN,
        DIGIT,
        CR,
        LF,
        ESC
    } state_t;

    state_t          state;
    logic [CW-1:0]   dig_cnt;
    logic [W-1:0]    value_q;
    logic            abort_pend;

    logic            xfer;
    logic            abort_hit;
    logic            go_esc;

    // Letter offset folds the -10 into the base: 'a'-10 = 0x57, 'A'-10 = 0x37.
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end else begin
            return ((UPPER != 0) ? 8'h37 : 8'h57) + {4'h0, nib};
        end
    endfunction

    assign xfer      = txValid && txReady;
    // Abort only counts while a message is being sent and ESC is not yet chosen.
    assign abort_hit = abort && (state != IDLE) && (state != ESC);
    // A transfer with a pending or simultaneous abort diverts to ESC.
    assign go_esc    = abort_pend || abort_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dig_cnt    <= '0;
            value_q    <= '0;
            abort_pend <= 1'b0;
            txData     <= 8'h00;
            txValid    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;

            if (abort_hit) begin
                abort_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (send) begin
                        value_q <= value;
                        dig_cnt <= '0;
                        txData  <= neg ? CH_MINUS : CH_PLUS;
                        txValid <= 1'b1;
                        busy    <= 1'b1;
                        state   <= SIGN;
                    end
                end

                default: begin
                    if (xfer) begin
                        if ((state != ESC) && go_esc) begin
                            txData <= CH_ESC;
                            state  <= ESC;
                        end else begin
                            case (state)
                                SIGN: begin
                                    // value_q is shifted so the next digit is
                                    // always the top nibble.
                                    txData  <= hex_char(value_q[W-1 -: 4]);
                                    value_q <= value_q << 4;
                                    dig_cnt <= '0;
                                    state   <= DIGIT;
                                end
                                DIGIT: begin
                                    if (dig_cnt == LAST_DIG) begin
                                        txData <= CH_CR;
                                        state  <= CR;
                                    end else begin
                                        txData  <= hex_char(value_q[W-1 -: 4]);
                                        value_q <= value_q << 4;
                                        dig_cnt <= dig_cnt + 1'b1;
                                    end
                                end
                                CR: begin
                                    txData <= CH_LF;
                                    state  <= LF;
                                end
                                default: begin
                                    // LF or ESC transferred: message complete.
                                    txValid    <= 1'b0;
                                    busy       <= 1'b0;
                                    done       <= 1'b1;
                                    abort_pend <= 1'b0;
                                    dig_cnt    <= '0;
                                    state      <= IDLE;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule
